// File: rtl/cic_i.sv
// CIC interpolator: m combs at the input rate, zero-stuffing upsampler, m integrators
// at the output rate. Valid/ready on both sides; every register holds when adv is low.

module cic_i_comb #(
    parameter int iw = 16,
    parameter int g  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [iw-1:0] din,
    output logic [iw:0]   dout
);
    logic [iw-1:0] dly [g];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < g; i++) dly[i] <= '0;
        end else if (en) begin
            dly[0] <= din;
            for (int i = 1; i < g; i++) dly[i] <= dly[i-1];
        end
    end

    // One bit of growth per comb so the difference never wraps
    assign dout = (iw+1)'($signed(din)) - (iw+1)'($signed(dly[g-1]));
endmodule

module cic_i #(
    parameter int idw = 16,
    parameter int odw = 16,
    parameter int r   = 8,
    parameter int m   = 3,
    parameter int g   = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [idw-1:0] data_in,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [odw-1:0] data_out,
    output logic           out_valid,
    input  logic           out_ready
);
    localparam int bw_a = idw + $clog2(((r * g) ** m) / r);
    localparam int bw_b = idw + m;
    localparam int bw   = (bw_a > bw_b) ? bw_a : bw_b;
    localparam int pw   = $clog2(r);

    logic [pw-1:0] phase;
    logic [m:0]    vld_pipe;
    logic          ph0, adv, acc_en;
    logic [bw-1:0] c  [m+1];
    logic [bw-1:0] st [m+1];

    assign ph0       = (phase == '0);
    assign out_valid = vld_pipe[m];
    assign in_ready  = ph0 & (~out_valid | out_ready);
    assign adv       = (~out_valid | out_ready) & (~ph0 | in_valid);
    assign acc_en    = adv & ph0;

    assign c[0] = bw'($signed(data_in));

    generate
        for (genvar j = 1; j <= m; j++) begin : g_comb
            logic [idw+j-1:0] cj;
            cic_i_comb #(.iw(idw + j - 1), .g(g)) u_comb (
                .clk  (clk),
                .reset(reset),
                .en   (acc_en),
                .din  (c[j-1][idw+j-2:0]),
                .dout (cj)
            );
            assign c[j] = bw'($signed(cj));
        end
    endgenerate

    // st[0] is the upsampler register, st[1..m] the integrators (wrap is intended)
    always_ff @(posedge clk) begin
        if (reset) begin
            phase    <= '0;
            vld_pipe <= '0;
            for (int k = 0; k <= m; k++) st[k] <= '0;
        end else if (adv) begin
            phase    <= (phase == pw'(r - 1)) ? '0 : phase + pw'(1);
            vld_pipe <= {vld_pipe[m-1:0], 1'b1};
            st[0]    <= ph0 ? c[m] : '0;
            for (int k = 1; k <= m; k++) st[k] <= st[k] + st[k-1];
        end
    end

    assign data_out = st[m][bw-1 -: odw];
endmodule

// File: tb/tb_cic_i.sv
// Bench for cic_i: reference is a direct convolution of the zero-stuffed input with
// the CIC impulse response, pushed to a scoreboard on accept and popped per output beat.

module tb_cic_i;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] data_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] data_out;
    logic        out_valid;
    logic        out_ready = 1'b0;

    cic_i dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .data_out (data_out),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    int          n_beat   = 0;
    int          steps    = 0;
    int          h [22];
    int          hist [1024];
    logic [15:0] sb [$];

    // h = (1 + z^-1 + ... + z^-7)^3
    task automatic build_h();
        int a [22];
        int b [22];
        for (int i = 0; i < 22; i++) a[i] = (i < 8) ? 1 : 0;
        repeat (2) begin
            for (int i = 0; i < 22; i++) begin
                b[i] = 0;
                for (int k = 0; k < 8; k++) if (i - k >= 0) b[i] += a[i-k];
            end
            a = b;
        end
        h = a;
    endtask

    function automatic int y_at(int n);
        int s = 0;
        for (int k = 0; k < 22; k++) begin
            int j = n - k;
            if (j >= 0 && (j % 8) == 0) s += h[k] * hist[j/8];
        end
        return s;
    endfunction

    task automatic clear_model();
        sb.delete();
        n_acc  = 0;
        n_beat = 0;
        steps  = 0;
    endtask

    task automatic do_reset(int n);
        reset = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
    endtask

    // One clock: observe the handshakes that the coming edge will perform.
    // A beat is a consumed output: out_valid & out_ready & the block advancing.
    task automatic tick(output bit beat, output logic [15:0] got, output logic [15:0] exp,
                        output bit have);
        @(negedge clk);
        beat = out_valid && out_ready && (in_valid || !in_ready);
        got  = data_out;
        exp  = '0;
        have = 1'b0;
        if (in_valid && in_ready && n_acc < 1024) begin
            hist[n_acc] = int'($signed(data_in));
            for (int q = 0; q < 8; q++) sb.push_back(16'(y_at(8 * n_acc + q) >>> 6));
            n_acc++;
        end
        if (beat) begin
            n_beat++;
            if (sb.size() > 0) begin
                exp  = sb.pop_front();
                have = 1'b1;
            end
        end
        if ((in_valid || !in_ready) && (!out_valid || out_ready)) steps++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit beat, have;
        logic [15:0] got, exp;
        in_valid = 1'b1; data_in = 16'd777; out_ready = 1'b1;
        repeat (13) tick(beat, got, exp, have);
        do_reset(3);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (data_out !== 16'd0) begin n_fail++; $display("FAIL rst_data_out: got %0d exp 0", $signed(data_out)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
    endtask

    task automatic test_dc(input int val, input bit rst, input string name);
        bit beat, have;
        logic [15:0] got, exp;
        if (rst) do_reset(2);
        in_valid = 1'b1; data_in = 16'(val); out_ready = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick(beat, got, exp, have);
            if (beat) begin
                n_checks++;
                if (!have || got !== exp) begin n_fail++; $display("FAIL %s_sb: got %0d exp %0d", name, $signed(got), $signed(exp)); end
                if (n_beat > 40) begin
                    n_checks++;
                    if (got !== 16'(val)) begin n_fail++; $display("FAIL %s_settle: got %0d exp %0d", name, $signed(got), val); end
                end
            end
        end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b exp 1", name, out_valid); end
    endtask

    task automatic test_impulse();
        bit beat, have;
        logic [15:0] got, exp;
        int sum = 0;
        int idx;
        int first [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
        do_reset(2);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && n_beat < 48; cyc++) begin
            data_in = (n_acc == 0) ? 16'd64 : 16'd0;
            if (cyc < 6) begin
                n_checks++;
                if (out_valid !== (cyc >= 4)) begin n_fail++; $display("FAIL imp_fill: cycle %0d got %b exp %b", cyc, out_valid, cyc >= 4); end
            end
            idx = n_beat;
            tick(beat, got, exp, have);
            if (beat) begin
                sum += int'($signed(got));
                n_checks++;
                if (!have || got !== exp) begin n_fail++; $display("FAIL imp_sb: got %0d exp %0d", $signed(got), $signed(exp)); end
                if (idx < 8) begin
                    n_checks++;
                    if (got !== 16'(first[idx])) begin n_fail++; $display("FAIL imp_first: idx %0d got %0d exp %0d", idx, $signed(got), first[idx]); end
                end
            end
        end
        n_checks++; if (n_beat < 48) begin n_fail++; $display("FAIL imp_timeout: got %0d beats exp 48", n_beat); end
        n_checks++; if (sum != 512) begin n_fail++; $display("FAIL imp_sum: got %0d exp 512", sum); end
    endtask

    task automatic test_backpressure();
        bit beat, have;
        logic [15:0] got, exp;
        int sum = 0;
        int idx;
        int first [8] = '{1, 3, 6, 10, 15, 21, 28, 36};
        do_reset(2);
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 1000 && n_beat < 48; cyc++) begin
            data_in   = (n_acc == 0) ? 16'd64 : 16'd0;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && !out_ready) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
            end
            idx = n_beat;
            tick(beat, got, exp, have);
            if (beat) begin
                sum += int'($signed(got));
                n_checks++;
                if (!have || got !== exp) begin n_fail++; $display("FAIL bp_sb: got %0d exp %0d", $signed(got), $signed(exp)); end
                if (idx < 8) begin
                    n_checks++;
                    if (got !== 16'(first[idx])) begin n_fail++; $display("FAIL bp_first: idx %0d got %0d exp %0d", idx, $signed(got), first[idx]); end
                end
            end
        end
        n_checks++; if (n_beat < 48) begin n_fail++; $display("FAIL bp_timeout: got %0d beats exp 48", n_beat); end
        n_checks++; if (sum != 512) begin n_fail++; $display("FAIL bp_sum: got %0d exp 512", sum); end
    endtask

    task automatic test_starvation();
        bit beat, have;
        logic [15:0] got, exp, frozen;
        int stv [6] = '{500, -1200, 3000, -700, 2500, -32000};
        bit starved = 1'b0;
        do_reset(2);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 400 && n_beat < 64; cyc++) begin
            data_in = (n_acc < 6) ? 16'(stv[n_acc]) : 16'd0;
            if (!starved && n_acc == 3 && in_ready) begin
                starved  = 1'b1;
                in_valid = 1'b0;
                frozen   = data_out;
                for (int s = 0; s < 20; s++) begin
                    tick(beat, got, exp, have);
                    n_checks++;
                    if (got !== frozen) begin n_fail++; $display("FAIL stv_frozen: got %0d exp %0d", $signed(got), $signed(frozen)); end
                    n_checks++;
                    if (beat) begin n_fail++; $display("FAIL stv_beat: got 1 exp 0"); end
                end
                in_valid = 1'b1;
            end
            tick(beat, got, exp, have);
            if (beat) begin
                n_checks++;
                if (!have || got !== exp) begin n_fail++; $display("FAIL stv_sb: got %0d exp %0d", $signed(got), $signed(exp)); end
            end
        end
        n_checks++; if (!starved || n_beat < 64) begin n_fail++; $display("FAIL stv_timeout: got %0d beats exp 64", n_beat); end
    endtask

    task automatic test_midrun_reset();
        bit beat, have;
        logic [15:0] got, exp;
        do_reset(2);
        in_valid = 1'b1; data_in = 16'd1000; out_ready = 1'b1;
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (steps >= 21 && (steps % 8) == 5) break;
            tick(beat, got, exp, have);
        end
        n_checks++; if ((steps % 8) != 5) begin n_fail++; $display("FAIL mid_phase: got %0d exp 5", steps % 8); end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid: got %b exp 0", out_valid); end
        n_checks++; if (data_out !== 16'd0) begin n_fail++; $display("FAIL mid_data_out: got %0d exp 0", $signed(data_out)); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_in_ready: got %b exp 1", in_ready); end
        reset = 1'b0;
        clear_model();
        test_dc(1000, 1'b0, "mid_dc");
    endtask

    initial begin
        build_h();
        test_reset();
        test_dc(1000, 1'b1, "dc_pos");
        test_dc(-1000, 1'b1, "dc_neg");
        test_dc(-32768, 1'b1, "dc_fs");
        test_impulse();
        test_backpressure();
        test_starvation();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
